// File: rtl/cmt_stream_engine.sv
// cmt_stream_engine: sub-MCU byte pump between tape byte streams and the 8251 CMT register block
// Optional feature: define CMT_TIMEOUT_EN to enable the acknowledge watchdog driving O_ERR.
// Ports: I_CLK clock, I_RST sync active-high reset; I_CMT_LOAD/I_CMT_SAVE 8251 mode bits;
//   I_nCMTRxRDY/I_nCMTTxRDY 8251 status levels; O_MCU_WR/O_MCU_RD strobes, O_MCU_DATA/I_MCU_DATA
//   8251 data; I_LOAD_DATA/I_LOAD_VALID/O_LOAD_READY upstream load stream;
//   O_SAVE_DATA/O_SAVE_VALID/I_SAVE_READY downstream save stream; O_BYTE_COUNT session byte
//   count; O_ERR sticky watchdog error.
module cmt_stream_engine #(
  parameter int STROBE_LEN     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        I_CLK,
  input  logic        I_RST,
  input  logic        I_CMT_LOAD,
  input  logic        I_CMT_SAVE,
  input  logic        I_nCMTRxRDY,
  input  logic        I_nCMTTxRDY,
  output logic        O_MCU_WR,
  output logic        O_MCU_RD,
  output logic [7:0]  O_MCU_DATA,
  input  logic [7:0]  I_MCU_DATA,
  input  logic [7:0]  I_LOAD_DATA,
  input  logic        I_LOAD_VALID,
  output logic        O_LOAD_READY,
  output logic [7:0]  O_SAVE_DATA,
  output logic        O_SAVE_VALID,
  input  logic        I_SAVE_READY,
  output logic [15:0] O_BYTE_COUNT,
  output logic        O_ERR
);
  typedef enum logic [3:0] {
    IDLE, L_STROBE, L_ACK, L_CONSUME, S_PRIME, S_PRIME_ACK, S_WAIT, S_STROBE, S_ACK, S_PUSH
  } state_t;
  state_t state, nxt;
  logic [3:0] stb_cnt;
  logic stb_st, stb_done, ld_fire, capture, push_done, load_done, timeout;
  // Strobe states last STROBE_LEN high cycles plus one low cycle, guaranteeing a gap between pulses.
  assign stb_st    = state inside {L_STROBE, S_PRIME, S_STROBE};
  assign stb_done  = stb_cnt == 4'(STROBE_LEN);
  assign ld_fire   = O_LOAD_READY & I_LOAD_VALID;
  assign capture   = state == S_ACK && nxt == S_PUSH;
  assign push_done = state == S_PUSH && I_SAVE_READY;
  assign load_done = state == L_CONSUME && I_CMT_LOAD && !I_nCMTRxRDY;
`ifdef CMT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
  logic ack_st, err;
  assign ack_st  = state inside {L_ACK, S_PRIME_ACK, S_ACK};
  assign timeout = ack_st && wd == WD_W'(TIMEOUT_CYCLES - 1);
  assign O_ERR   = err;
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      wd  <= (ack_st && nxt == state) ? wd + WD_W'(1) : '0;
      err <= timeout ? 1'b1 : (state == IDLE && !I_CMT_LOAD && !I_CMT_SAVE) ? 1'b0 : err;
    end
  end
`else
  assign timeout = 1'b0;
  assign O_ERR   = (TIMEOUT_CYCLES < 0);
`endif
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state        <= IDLE;
      stb_cnt      <= '0;
      O_MCU_DATA   <= '0;
      O_SAVE_DATA  <= '0;
      O_SAVE_VALID <= 1'b0;
      O_BYTE_COUNT <= '0;
    end else begin
      state        <= nxt;
      stb_cnt      <= (stb_st && !stb_done) ? stb_cnt + 4'd1 : 4'd0;
      O_MCU_DATA   <= ld_fire ? I_LOAD_DATA : O_MCU_DATA;
      O_SAVE_DATA  <= capture ? I_MCU_DATA : O_SAVE_DATA;
      O_SAVE_VALID <= capture ? 1'b1 : push_done ? 1'b0 : O_SAVE_VALID;
      O_BYTE_COUNT <= (state == IDLE && !I_CMT_LOAD && !I_CMT_SAVE) ? 16'd0
                    : O_BYTE_COUNT + 16'(load_done | push_done);
    end
  end
  // Wait states bail to IDLE when their mode bit drops; strobes and S_PUSH always run to completion.
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:        nxt = ld_fire ? L_STROBE : I_CMT_SAVE ? S_PRIME : IDLE;
      L_STROBE:    nxt = stb_done ? L_ACK : L_STROBE;
      L_ACK:       nxt = !I_CMT_LOAD ? IDLE : I_nCMTRxRDY ? L_CONSUME : L_ACK;
      L_CONSUME:   nxt = (!I_CMT_LOAD || !I_nCMTRxRDY) ? IDLE : L_CONSUME;
      S_PRIME:     nxt = stb_done ? S_PRIME_ACK : S_PRIME;
      S_PRIME_ACK: nxt = !I_CMT_SAVE ? IDLE : I_nCMTTxRDY ? S_WAIT : S_PRIME_ACK;
      S_WAIT:      nxt = !I_CMT_SAVE ? IDLE : !I_nCMTTxRDY ? S_STROBE : S_WAIT;
      S_STROBE:    nxt = stb_done ? S_ACK : S_STROBE;
      S_ACK:       nxt = !I_CMT_SAVE ? IDLE : I_nCMTTxRDY ? S_PUSH : S_ACK;
      S_PUSH:      nxt = I_SAVE_READY ? S_WAIT : S_PUSH;
      default:     nxt = IDLE;
    endcase
    if (timeout) nxt = IDLE;
  end
  always_comb begin
    O_MCU_WR     = state == L_STROBE && !stb_done;
    O_MCU_RD     = (state == S_PRIME || state == S_STROBE) && !stb_done;
    O_LOAD_READY = state == IDLE && I_CMT_LOAD && !I_nCMTRxRDY && !I_RST;
  end
endmodule
